led_sequence_controller: RTL and testbench

- Drives a small LED bank from a single push-button, cycling through display modes: OFF, HOLD, BLINK, CHASE.
- Each debounced press advances the mode. HOLD is a timed on-pulse that times out back to OFF; BLINK and CHASE run until the next press.
- Sits between the raw board button pin and the LED pins. It replaces per-LED timer blocks with one sequenced controller.

---
 rtl/led_sequence_controller_pkg.sv | 26 ++
 rtl/led_sequence_controller_if.sv | 11 +
 rtl/led_sequence_controller_debouncer.sv | 52 +++++
 rtl/led_sequence_controller.sv | 114 +++++++++++
 tb/tb_led_sequence_controller.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/led_sequence_controller_pkg.sv
// Shared mode encodings, default tick counts and timer sizing for the LED sequencer.
package led_seq_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_HOLD  = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_CHASE = 2'd3;

    localparam int DEF_N_LEDS         = 4;
    localparam int DEF_DEBOUNCE_TICKS = 500_000;
    localparam int DEF_HOLD_TICKS     = 25_000_000;
    localparam int DEF_BLINK_TICKS    = 12_500_000;
    localparam int DEF_STEP_TICKS     = 6_250_000;

    // Width of the shared down-counter; kept at least 1 bit for tiny periods.
    function automatic int timer_w(input int a, input int b, input int c);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/led_sequence_controller_if.sv
// Button-in / LED-out bundle between the board pins and the sequencer.
interface led_seq_if #(
    parameter int N_LEDS = 4
);
    logic              i_press;
    logic [N_LEDS-1:0] o_leds;
    logic [1:0]        o_mode;

    modport master (output i_press, input o_leds, input o_mode);
    modport slave  (input i_press, output o_leds, output o_mode);
endinterface

// File: rtl/led_sequence_controller_debouncer.sv
// Synchronises the raw button, debounces it and emits a one-cycle pulse on each
// accepted rising level.
module button_debouncer #(
    parameter int DEBOUNCE_TICKS = 500_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = s2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= i_raw;
            s2_q    <= s1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    assign o_level = level_q;
    assign o_press = level_q & ~prev_q;

endmodule

// File: rtl/led_sequence_controller.sv
// Single-button LED mode sequencer: OFF -> HOLD -> BLINK -> CHASE -> OFF, one shared
// down-counter paces the timed on-pulse, the blink phases and the chase steps.
module led_sequence_controller
    import led_seq_pkg::*;
#(
    parameter int N_LEDS         = DEF_N_LEDS,
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int HOLD_TICKS     = DEF_HOLD_TICKS,
    parameter int BLINK_TICKS    = DEF_BLINK_TICKS,
    parameter int STEP_TICKS     = DEF_STEP_TICKS
) (
    input  logic     i_clk,
    input  logic     i_rst,
    led_seq_if.slave bus
);
    localparam int TW = timer_w(HOLD_TICKS, BLINK_TICKS, STEP_TICKS);
    localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_TICKS - 1);
    localparam logic [TW-1:0] BLINK_LOAD = TW'(BLINK_TICKS - 1);
    localparam logic [TW-1:0] STEP_LOAD  = TW'(STEP_TICKS - 1);
    localparam logic [N_LEDS-1:0] ALL_ON = '1;
    localparam logic [N_LEDS-1:0] BIT0   = N_LEDS'(1);

    logic              press;
    logic              level_unused;
    logic [1:0]        state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [N_LEDS-1:0] leds_q, leds_d;
    logic              tmo;

    button_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_raw  (bus.i_press),
        .o_level(level_unused),
        .o_press(press)
    );

    assign tmo = (timer_q == '0);

    // A press always wins over a coincident timeout, so it is decoded first.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        leds_d  = leds_q;
        if (press) begin
            case (state_q)
                MODE_OFF: begin
                    state_d = MODE_HOLD;
                    timer_d = HOLD_LOAD;
                    leds_d  = ALL_ON;
                end
                MODE_HOLD: begin
                    state_d = MODE_BLINK;
                    timer_d = BLINK_LOAD;
                    leds_d  = ALL_ON;
                end
                MODE_BLINK: begin
                    state_d = MODE_CHASE;
                    timer_d = STEP_LOAD;
                    leds_d  = BIT0;
                end
                default: begin
                    state_d = MODE_OFF;
                    timer_d = '0;
                    leds_d  = '0;
                end
            endcase
        end else begin
            case (state_q)
                MODE_HOLD: begin
                    if (tmo) begin
                        state_d = MODE_OFF;
                        leds_d  = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                MODE_BLINK: begin
                    if (tmo) begin
                        leds_d  = ~leds_q;
                        timer_d = BLINK_LOAD;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                MODE_CHASE: begin
                    if (tmo) begin
                        leds_d  = {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
                        timer_d = STEP_LOAD;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= MODE_OFF;
            timer_q <= '0;
            leds_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            leds_q  <= leds_d;
        end
    end

    assign bus.o_leds = leds_q;
    assign bus.o_mode = state_q;

endmodule

// File: tb/tb_led_sequence_controller.sv
// Scoreboard bench: a per-edge model derived from mode age pushes expected outputs,
// a negedge monitor pops and compares against the DUT.
module tb_led_sequence_controller;
    localparam int NL = 4;
    localparam int DB = 4;
    localparam int HT = 10;
    localparam int BT = 3;
    localparam int ST = 2;

    typedef struct packed {
        logic [NL-1:0] leds;
        logic [1:0]    mode;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_seq_if #(.N_LEDS(NL)) bus ();

    led_sequence_controller #(
        .N_LEDS(NL), .DEBOUNCE_TICKS(DB), .HOLD_TICKS(HT),
        .BLINK_TICKS(BT), .STEP_TICKS(ST)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [NL-1:0] exp_leds(input int mode, input int age);
        int sh;
        case (mode)
            1: return '1;
            2: return (((age / BT) % 2) == 0) ? '1 : '0;
            3: begin
                sh = (age / ST) % NL;
                return NL'(1 << sh);
            end
            default: return '0;
        endcase
    endfunction

    // Reference: level flips after DB consecutive differing synchronised samples;
    // a rising flip advances the mode one edge later; outputs follow from mode age.
    initial begin : model
        int s1, s2, lvl, run, evt, mode, age;
        exp_t e;
        s1 = 0; s2 = 0; lvl = 0; run = 0; evt = 0; mode = 0; age = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                s1 = 0; s2 = 0; lvl = 0; run = 0; evt = 0; mode = 0; age = 0;
                e = '0;
            end else begin
                age++;
                if (evt != 0) begin
                    mode = (mode + 1) % 4;
                    age  = 0;
                end else if (mode == 1 && age == HT) begin
                    mode = 0;
                end
                e.mode = 2'(mode);
                e.leds = exp_leds(mode, age);
                evt = 0;
                if (s2 != lvl) begin
                    run++;
                    if (run == DB) begin
                        lvl = s2;
                        run = 0;
                        evt = lvl;
                    end
                end else begin
                    run = 0;
                end
                s2 = s1;
                s1 = int'(bus.i_press);
            end
            q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (bus.o_mode !== e.mode) begin
                    failures++;
                    $display("FAIL mode t=%0t got=%0d want=%0d", $time, bus.o_mode, e.mode);
                end
                checks++;
                if (bus.o_leds !== e.leds) begin
                    failures++;
                    $display("FAIL leds t=%0t got=%b want=%b", $time, bus.o_leds, e.leds);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic p, input int n);
        repeat (n) begin
            rst = r;
            bus.i_press = p;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_seq(input int hi, input int lo, input int n);
        repeat (n) begin
            cyc(1'b0, 1'b1, hi);
            cyc(1'b0, 1'b0, lo);
        end
    endtask

    initial begin : stim
        bus.i_press = 1'($urandom_range(0, 1));
        // reset with a noisy button
        repeat (2) cyc(1'b1, 1'($urandom_range(0, 1)), 1);
        // HOLD pulse and timeout
        cyc(1'b0, 1'b1, 20);
        cyc(1'b0, 1'b0, 10);
        // glitch shorter than the debounce window
        cyc(1'b0, 1'b1, 3);
        cyc(1'b0, 1'b0, 15);
        // four presses at 8 high / 8 low
        press_seq(8, 8, 4);
        cyc(1'b0, 1'b0, 10);
        // fast presses reach BLINK inside HOLD, then CHASE, then OFF
        cyc(1'b1, 1'b0, 1);
        press_seq(4, 5, 4);
        cyc(1'b0, 1'b0, 8);
        // second press lands exactly on the HOLD timeout edge
        cyc(1'b1, 1'b0, 1);
        cyc(1'b0, 1'b1, 6);
        cyc(1'b0, 1'b0, 4);
        cyc(1'b0, 1'b1, 8);
        cyc(1'b0, 1'b0, 12);
        // reset mid-CHASE with the button held through deassertion
        cyc(1'b1, 1'b0, 1);
        press_seq(4, 5, 3);
        cyc(1'b0, 1'b0, 7);
        cyc(1'b1, 1'b1, 2);
        cyc(1'b0, 1'b1, 14);
        cyc(1'b0, 1'b0, 8);
        // random button activity with occasional resets
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 19) == 0)
                cyc(1'b1, 1'($urandom_range(0, 1)), 1);
            cyc(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
        end
        cyc(1'b0, 1'b0, 3);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
